// File: rtl/fifo_drain_pkg.sv
// Shared constants and elaboration helpers for the FIFO read-side drain serializer.
package fifo_drain_pkg;

    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned PTR_WIDTH = 2;
    localparam int unsigned OCC_WIDTH = 3;

    function automatic int unsigned calc_ratio(input int unsigned data_width,
                                               input int unsigned out_width);
        return data_width / out_width;
    endfunction

    function automatic bit ratio_ok(input int unsigned data_width,
                                    input int unsigned out_width);
        return (out_width != 0) && (out_width <= data_width) && (data_width % out_width == 0);
    endfunction

endpackage

// File: rtl/drain_word_buffer.sv
// Four-entry synchronous word buffer; the caller guarantees no push when full and no pop when empty.
module drain_word_buffer
    import fifo_drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [OCC_WIDTH-1:0]  occupancy_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_WIDTH-1:0]  head_q, head_d;
    logic [PTR_WIDTH-1:0]  tail_q, tail_d;
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push_i) tail_d = tail_q + 1'b1;
        if (pop_i)  head_d = head_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[head_q];
    assign occupancy_o = occ_q;

endmodule

// File: rtl/fifo_drain_serializer.sv
// Pops words from the dual-clock FIFO read port, buffers up to four, and streams each word
// out MSB chunk first on a valid/ready interface.
module fifo_drain_serializer
    import fifo_drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Clear_in,
    input  logic [DATA_WIDTH-1:0]  FifoData_in,
    input  logic                   FifoEmpty_in,
    output logic                   FifoReadEn_out,
    input  logic                   Enable_in,
    output logic [OUT_WIDTH-1:0]   Data_out,
    output logic                   Valid_out,
    input  logic                   Ready_in,
    output logic                   Last_out,
    output logic [COUNT_WIDTH-1:0] WordCount_out
);

    localparam int unsigned RATIO     = calc_ratio(DATA_WIDTH, OUT_WIDTH);
    localparam int unsigned IDX_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);

    if (!ratio_ok(DATA_WIDTH, OUT_WIDTH)) begin : g_ratio_check
        $fatal(1, "OUT_WIDTH must divide DATA_WIDTH exactly");
    end

    logic                   pending_q;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [OCC_WIDTH-1:0]   occ;
    logic [OCC_WIDTH:0]     committed;
    logic [DATA_WIDTH-1:0]  head_data;
    logic [DATA_WIDTH-1:0]  head_shifted;
    logic                   at_last;
    logic                   xfer;
    logic                   pop;

    // Words already buffered plus the one still in flight from the FIFO's registered read.
    assign committed = {1'b0, occ} + (OCC_WIDTH + 1)'(pending_q);

    assign FifoReadEn_out = !Clear_in && Enable_in && !FifoEmpty_in
                            && (committed < (OCC_WIDTH + 1)'(BUF_DEPTH));

    assign at_last      = (idx_q == LAST_IDX);
    assign Valid_out    = (occ != '0);
    assign Last_out     = Valid_out && at_last;
    assign xfer         = Valid_out && Ready_in;
    assign pop          = xfer && at_last;
    assign head_shifted = head_data << (idx_q * OUT_WIDTH);
    assign Data_out     = head_shifted[DATA_WIDTH-1 -: OUT_WIDTH];
    assign WordCount_out = count_q;

    always_comb begin
        idx_d   = idx_q;
        count_d = count_q;
        if (xfer) begin
            if (at_last) begin
                idx_d   = '0;
                count_d = count_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            pending_q <= 1'b0;
            idx_q     <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= FifoReadEn_out;
            idx_q     <= idx_d;
            count_q   <= count_d;
        end
    end

    drain_word_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_buffer (
        .clk_i       (Clk),
        .clear_i     (Clear_in),
        .push_i      (pending_q),
        .push_data_i (FifoData_in),
        .pop_i       (pop),
        .head_data_o (head_data),
        .occupancy_o (occ)
    );

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: a 16->8 instance and an 8->8 instance, each fed by a
// behavioural registered-read FIFO, checked against a word-queue reference model.
module tb_fifo_drain_serializer;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Clear  = 1'b1;
    logic Enable = 1'b0;
    logic Ready  = 1'b0;

    logic [15:0] fdata_a = '0;
    logic        fempty_a, rden_a, valid_a, last_a;
    logic [7:0]  dout_a;
    logic [15:0] wc_a;

    logic [7:0]  fdata_b = '0;
    logic        fempty_b, rden_b, valid_b, last_b;
    logic [7:0]  dout_b;
    logic [15:0] wc_b;

    fifo_drain_serializer #(
        .DATA_WIDTH (16), .OUT_WIDTH (8), .COUNT_WIDTH (16)
    ) u_dut_a (
        .Clk (Clk), .Clear_in (Clear), .FifoData_in (fdata_a), .FifoEmpty_in (fempty_a),
        .FifoReadEn_out (rden_a), .Enable_in (Enable), .Data_out (dout_a),
        .Valid_out (valid_a), .Ready_in (Ready), .Last_out (last_a), .WordCount_out (wc_a)
    );

    fifo_drain_serializer #(
        .DATA_WIDTH (8), .OUT_WIDTH (8), .COUNT_WIDTH (16)
    ) u_dut_b (
        .Clk (Clk), .Clear_in (Clear), .FifoData_in (fdata_b), .FifoEmpty_in (fempty_b),
        .FifoReadEn_out (rden_b), .Enable_in (Enable), .Data_out (dout_b),
        .Valid_out (valid_b), .Ready_in (Ready), .Last_out (last_b), .WordCount_out (wc_b)
    );

    // Source FIFOs with one-cycle registered read data; cleared by the same Clear.
    logic [15:0] mem_a [256];
    logic [7:0]  mem_b [256];
    int wr_a = 0, rd_a = 0, reads_a = 0;
    int wr_b = 0, rd_b = 0;

    assign fempty_a = (wr_a == rd_a);
    assign fempty_b = (wr_b == rd_b);

    always @(posedge Clk) begin
        if (Clear) begin
            rd_a <= wr_a;
            rd_b <= wr_b;
        end else begin
            if (rden_a) begin
                fdata_a <= mem_a[rd_a[7:0]];
                rd_a    <= rd_a + 1;
                reads_a <= reads_a + 1;
            end
            if (rden_b) begin
                fdata_b <= mem_b[rd_b[7:0]];
                rd_b    <= rd_b + 1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int exp_wc_a = 0;
    int exp_wc_b = 0;
    logic [15:0] exp_q [$];

    function automatic logic [7:0] chunk_a(input logic [15:0] w, input int k);
        logic [15:0] s;
        s = w >> (8 * (1 - k));
        return s[7:0];
    endfunction

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic push_a(input logic [15:0] w);
        mem_a[wr_a[7:0]] = w;
        wr_a = wr_a + 1;
    endtask

    task automatic push_b(input logic [7:0] w);
        mem_b[wr_b[7:0]] = w;
        wr_b = wr_b + 1;
    endtask

    task automatic test_reset();
        Clear = 1'b1; Enable = 1'b1; Ready = 1'b0;
        push_a(16'h1111);
        push_b(8'h22);
        #1;
        n_checks++;
        if ({rden_a, rden_b} !== 2'b00) begin
            n_errors++; $display("FAIL reset_rden: got %b want 00", {rden_a, rden_b});
        end
        step();
        step();
        n_checks++;
        if ({valid_a, last_a, valid_b, last_b} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_valid: got %b want 0000",
                                 {valid_a, last_a, valid_b, last_b});
        end
        n_checks++;
        if (wc_a !== 16'd0 || wc_b !== 16'd0) begin
            n_errors++; $display("FAIL reset_count: got %0h/%0h want 0/0", wc_a, wc_b);
        end
        Clear = 1'b0;
        step();
        n_checks++;
        if (valid_a !== 1'b0) begin
            n_errors++; $display("FAIL reset_idle: got valid %b want 0", valid_a);
        end
    endtask

    task automatic test_single_word();
        logic [15:0] w;
        w = 16'hA55A;
        Enable = 1'b1; Ready = 1'b1;
        push_a(w);
        #1;
        n_checks++;
        if (rden_a !== 1'b1) begin
            n_errors++; $display("FAIL single_rden: got %b want 1", rden_a);
        end
        step();
        n_checks++;
        if (valid_a !== 1'b0) begin
            n_errors++; $display("FAIL single_early: got valid %b want 0", valid_a);
        end
        step();
        n_checks++;
        if ({valid_a, last_a, dout_a} !== {2'b10, chunk_a(w, 0)}) begin
            n_errors++; $display("FAIL single_chunk0: got v%b l%b %0h want v1 l0 %0h",
                                 valid_a, last_a, dout_a, chunk_a(w, 0));
        end
        step();
        n_checks++;
        if ({valid_a, last_a, dout_a} !== {2'b11, chunk_a(w, 1)}) begin
            n_errors++; $display("FAIL single_chunk1: got v%b l%b %0h want v1 l1 %0h",
                                 valid_a, last_a, dout_a, chunk_a(w, 1));
        end
        exp_wc_a++;
        step();
        n_checks++;
        if (valid_a !== 1'b0 || wc_a !== 16'(exp_wc_a)) begin
            n_errors++; $display("FAIL single_done: got v%b count %0d want v0 count %0d",
                                 valid_a, wc_a, exp_wc_a);
        end
    endtask

    task automatic test_backpressure();
        int base, k, guard;
        logic [15:0] w;
        Ready = 1'b0; Enable = 1'b1;
        base = reads_a;
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            push_a(w);
            exp_q.push_back(w);
        end
        for (int c = 0; c < 12; c++) begin
            step();
            if (c >= 2) begin
                n_checks++;
                if ({valid_a, dout_a} !== {1'b1, chunk_a(exp_q[0], 0)}) begin
                    n_errors++; $display("FAIL bp_hold: got v%b %0h want v1 %0h",
                                         valid_a, dout_a, chunk_a(exp_q[0], 0));
                end
            end
        end
        n_checks++;
        if (reads_a - base !== 4) begin
            n_errors++; $display("FAIL bp_reads: got %0d want 4", reads_a - base);
        end
        Ready = 1'b1;
        k = 0; guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            if (valid_a) begin
                n_checks++;
                if (dout_a !== chunk_a(exp_q[0], k) || last_a !== (k == 1)) begin
                    n_errors++; $display("FAIL bp_drain: got %0h l%b want %0h l%b",
                                         dout_a, last_a, chunk_a(exp_q[0], k), (k == 1));
                end
                if (k == 1) begin
                    void'(exp_q.pop_front());
                    exp_wc_a++;
                    k = 0;
                end else begin
                    k = 1;
                end
            end
            step();
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0 || valid_a !== 1'b0 || wc_a !== 16'(exp_wc_a)) begin
            n_errors++; $display("FAIL bp_end: got left %0d v%b count %0d want 0 v0 %0d",
                                 exp_q.size(), valid_a, wc_a, exp_wc_a);
        end
        exp_q.delete();
    endtask

    task automatic test_full_rate();
        Ready = 1'b1; Enable = 1'b1;
        for (int i = 0; i < 100; i++) push_b(8'(i * 7 + 3));
        step();
        n_checks++;
        if (valid_b !== 1'b0) begin
            n_errors++; $display("FAIL rate_latency: got valid %b want 0", valid_b);
        end
        step();
        for (int i = 0; i < 100; i++) begin
            n_checks++;
            if ({valid_b, last_b, dout_b} !== {2'b11, 8'(i * 7 + 3)}) begin
                n_errors++; $display("FAIL rate_word%0d: got v%b l%b %0h want v1 l1 %0h",
                                     i, valid_b, last_b, dout_b, 8'(i * 7 + 3));
            end
            exp_wc_b++;
            step();
        end
        n_checks++;
        if (valid_b !== 1'b0 || wc_b !== 16'(exp_wc_b)) begin
            n_errors++; $display("FAIL rate_count: got v%b count %0d want v0 count %0d",
                                 valid_b, wc_b, exp_wc_b);
        end
    endtask

    task automatic test_enable_drop();
        int base, k;
        logic [15:0] w0;
        Ready = 1'b0; Enable = 1'b1;
        w0 = 16'($urandom);
        base = reads_a;
        push_a(w0);
        push_a(16'($urandom));
        push_a(16'($urandom));
        exp_q.push_back(w0);
        #1;
        n_checks++;
        if (rden_a !== 1'b1) begin
            n_errors++; $display("FAIL en_issue: got %b want 1", rden_a);
        end
        step();
        Enable = 1'b0;
        Ready  = 1'b1;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            if (valid_a) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL en_extra: got word chunk %0h want none", dout_a);
                end else if (dout_a !== chunk_a(exp_q[0], k)) begin
                    n_errors++; $display("FAIL en_data: got %0h want %0h",
                                         dout_a, chunk_a(exp_q[0], k));
                end
                if (k == 1) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    exp_wc_a++;
                    k = 0;
                end else begin
                    k = 1;
                end
            end
            step();
        end
        n_checks++;
        if (exp_q.size() != 0 || reads_a - base !== 1 || wc_a !== 16'(exp_wc_a)) begin
            n_errors++; $display("FAIL en_end: got left %0d reads %0d count %0d want 0 1 %0d",
                                 exp_q.size(), reads_a - base, wc_a, exp_wc_a);
        end
        exp_q.delete();
    endtask

    task automatic test_clear_midstream();
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        exp_wc_a = 0;
        Ready = 1'b0; Enable = 1'b1;
        for (int i = 0; i < 8; i++) push_a(16'($urandom));
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if ({valid_a, rden_a} !== 2'b10) begin
            n_errors++; $display("FAIL clr_setup: got v%b rden%b want v1 rden0", valid_a, rden_a);
        end
        Clear = 1'b1;
        step();
        n_checks++;
        if ({valid_a, last_a, rden_a} !== 3'b000 || wc_a !== 16'd0) begin
            n_errors++; $display("FAIL clr_state: got v%b l%b r%b count %0d want 000 count 0",
                                 valid_a, last_a, rden_a, wc_a);
        end
        Clear = 1'b0; Ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if (valid_a !== 1'b0) begin
                n_errors++; $display("FAIL clr_stale: got valid %b chunk %0h want 0",
                                     valid_a, dout_a);
            end
        end
        push_a(16'h1234);
        step();
        step();
        n_checks++;
        if ({valid_a, dout_a} !== {1'b1, 8'h12}) begin
            n_errors++; $display("FAIL clr_new0: got v%b %0h want v1 12", valid_a, dout_a);
        end
        step();
        n_checks++;
        if ({valid_a, last_a, dout_a} !== {2'b11, 8'h34}) begin
            n_errors++; $display("FAIL clr_new1: got v%b l%b %0h want v1 l1 34",
                                 valid_a, last_a, dout_a);
        end
        exp_wc_a++;
        step();
        n_checks++;
        if (wc_a !== 16'(exp_wc_a)) begin
            n_errors++; $display("FAIL clr_count: got %0d want %0d", wc_a, exp_wc_a);
        end
    endtask

    task automatic test_random();
        int k, guard;
        logic [15:0] w;
        for (int i = 0; i < 20; i++) begin
            w = 16'($urandom);
            push_a(w);
            exp_q.push_back(w);
        end
        k = 0; guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            Ready  = ($urandom_range(0, 2) != 0);
            Enable = ($urandom_range(0, 3) != 0);
            if (valid_a) begin
                n_checks++;
                if (dout_a !== chunk_a(exp_q[0], k) || last_a !== (k == 1)) begin
                    n_errors++; $display("FAIL rnd_data: got %0h l%b want %0h l%b",
                                         dout_a, last_a, chunk_a(exp_q[0], k), (k == 1));
                end
                if (Ready) begin
                    if (k == 1) begin
                        void'(exp_q.pop_front());
                        exp_wc_a++;
                        k = 0;
                    end else begin
                        k = 1;
                    end
                end
            end
            step();
            guard++;
        end
        Enable = 1'b1; Ready = 1'b1;
        n_checks++;
        if (exp_q.size() != 0 || valid_a !== 1'b0 || wc_a !== 16'(exp_wc_a)) begin
            n_errors++; $display("FAIL rnd_end: got left %0d v%b count %0d want 0 v0 %0d",
                                 exp_q.size(), valid_a, wc_a, exp_wc_a);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_full_rate();
        test_enable_drop();
        test_clear_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_drain_serializer.md
# fifo_drain_serializer

Read-side consumer for the dual-clock FIFO, running entirely in the FIFO's read-clock domain. It pops words from the FIFO read port, accounts for the FIFO's one-cycle registered read latency, and buffers up to four words. It emits each word as DATA_WIDTH/OUT_WIDTH chunks, MSB chunk first, on a valid/ready stream toward downstream logic (audio/serial output path).

## Interface
Parameters:
- DATA_WIDTH, 8, FIFO word width; must equal the FIFO's DATA_WIDTH.
- OUT_WIDTH, 8, output chunk width; must divide DATA_WIDTH exactly.
- COUNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- Clk  in  1  read-side clock; same net as the FIFO's RClk.
- Clear_in  in  1  synchronous, active-high reset.
- FifoData_in  in  DATA_WIDTH  FIFO Data_out.
- FifoEmpty_in  in  1  FIFO Empty_out.
- FifoReadEn_out  out  1  FIFO ReadEn_in.
- Enable_in  in  1  permits new FIFO reads; draining continues regardless.
- Data_out  out  OUT_WIDTH  current chunk.
- Valid_out  out  1  Data_out holds a valid chunk.
- Ready_in  in  1  downstream accepts the chunk.
- Last_out  out  1  current chunk is the final chunk of its word.
- WordCount_out  out  COUNT_WIDTH  count of fully delivered words; wraps modulo 2^COUNT_WIDTH.

One clock; reset is synchronous and active-high (Clk, Clear_in).

## Operation
- RATIO = DATA_WIDTH/OUT_WIDTH.
- State:
  - 4-entry word buffer with 2-bit head/tail pointers and a 3-bit occupancy count.
  - pending flag: a read was issued last cycle.
  - chunk index: 0..RATIO-1.
  - WordCount register.
- Read issue (combinational): FifoReadEn_out = !Clear_in & Enable_in & !FifoEmpty_in & (occupancy + pending < 4).
- A FIFO read is accepted exactly when FifoReadEn_out = 1.
- pending <= FifoReadEn_out each cycle.
- When pending = 1, FifoData_in is written to the buffer tail that cycle, and the tail and occupancy advance.
- The buffer never overflows. This follows from the occupancy + pending guard.
- Output:
  - Valid_out = (occupancy != 0).
  - Data_out = head-word chunk selected by the index, chunk 0 = bits [DATA_WIDTH-1 -: OUT_WIDTH].
  - Last_out = Valid_out & (index == RATIO-1).
- Transfer occurs when Valid_out & Ready_in:
  - If index < RATIO-1: index increments.
  - Otherwise: index goes to 0, head advances, occupancy decrements, WordCount increments.
- Capture and pop in the same cycle leave occupancy unchanged.
- Enable_in low:
  - No new reads are issued.
  - An in-flight read is still captured.
  - Buffered words continue to drain.
- Data_out, Valid_out and Last_out are held stable while Valid_out & !Ready_in.
- RATIO = 1: Last_out equals Valid_out.

## Timing
- Reset values (cycle after Clear_in high):
  - Valid_out 0, Last_out 0, WordCount_out 0.
  - Buffer empty, pending 0, index 0.
  - FifoReadEn_out is 0 combinationally while Clear_in is high.
- Clear_in asserted during an in-flight read discards that data. The FIFO is cleared by the same Clear_in.
- Latency:
  - FifoEmpty_in falls in cycle N (buffer empty, Enable_in high), so FifoReadEn_out is 1 in cycle N.
  - Word captured at the end of N+1.
  - Valid_out is 1 in cycle N+2.
- Throughput:
  - RATIO = 1 with Ready_in held high sustains one word per cycle.
  - FifoReadEn_out has no combinational path from Ready_in.
- Backpressure: with Ready_in low, at most 4 words are buffered and reads stop. Reads resume in the cycle after occupancy + pending drops below 4.
- Wrap-around: pointers wrap 3 to 0. WordCount wraps all-ones to 0.

## Structure
- Package fifo_drain_pkg holds:
  - BUF_DEPTH = 4.
  - Pointer and occupancy widths.
  - A function computing RATIO and checking the divisibility constraint (elaboration-time assertion).
- One sub-module, drain_word_buffer: 4-entry synchronous FIFO with push, pop, head data and occupancy.
- The top level holds the read-issue logic, the pending flag, the chunk serializer and the counter.

## Test plan
- Reset and idle: Clear_in for 2 cycles with FifoEmpty_in = 0. Required: FifoReadEn_out = 0 during Clear_in, then Valid_out = 0 and WordCount_out = 0.
- Single word, DATA_WIDTH = 16, OUT_WIDTH = 8, FIFO word 0xA55A, Ready_in = 1. Required:
  - Valid_out rises 2 cycles after the read.
  - Chunks 0xA5 then 0x5A.
  - Last_out is 1 only on 0x5A.
  - WordCount_out = 1.
- Backpressure: 6 words queued, Ready_in = 0. Required:
  - Exactly 4 reads issued.
  - Data_out stable.
  - After Ready_in = 1, all 6 words delivered in order with no loss or duplication.
- Full rate, RATIO = 1, 100 sequential words, Ready_in = 1. Required:
  - One word per cycle after the initial 2-cycle latency.
  - WordCount_out = 100.
- Enable_in dropped in the same cycle as a read issue. Required: that word is still captured and delivered, and no further reads occur.
- Clear_in mid-stream (pending = 1, occupancy = 3). Required: next cycle Valid_out = 0, WordCount_out = 0, and no stale word appears afterwards.
